fetch_unit: RTL and testbench

//  Instruction fetch stage, directly downstream of the program counter.
//  - Reads the current PC (pc_addr) and issues one 16-bit read per instruction on a

---
 rtl/fetch_pkg.sv | 23 ++
 rtl/fetch_instr_queue.sv | 57 +++++
 rtl/fetch_unit.sv | 145 ++++++++++++++
 tb/tb_fetch_unit.sv | 279 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch stage: FSM states, queue entry layout, PC step.
// The optional performance counters in fetch_unit are enabled with FETCH_PERF_EN.
package fetch_pkg;

    localparam int FETCH_ADDR_W  = 16;
    localparam int FETCH_INSTR_W = 16;

    // The PC register advances by this amount on every pc_incr pulse.
    localparam logic [FETCH_ADDR_W-1:0] PC_STEP = 16'd2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        WAIT  = 2'd2,
        DRAIN = 2'd3
    } fetch_state_e;

    typedef struct packed {
        logic [FETCH_ADDR_W-1:0]  pc;
        logic [FETCH_INSTR_W-1:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_instr_queue.sv
// DEPTH-entry FIFO of fetched {pc, instr} pairs; flush empties it in one edge.
// Pop on empty is ignored; push when full only lands if a pop frees the slot.
module instr_queue
    import fetch_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               push_i,
    input  logic               pop_i,
    input  logic               flush_i,
    input  fetch_entry_t       wdata_i,
    output fetch_entry_t       rdata_o,
    output logic [CNT_W-1:0]   count_o,
    output logic               full_o,
    output logic               empty_o
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t        mem_q [DEPTH];
    logic [PTR_W-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0]    count_q;
    logic                do_push, do_pop;

    assign empty_o = (count_q == '0);
    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign count_o = count_q;
    assign rdata_o = mem_q[rd_ptr_q];

    assign do_pop  = pop_i & ~empty_o;
    assign do_push = push_i & (~full_o | do_pop);

    // DEPTH is a power of two, so pointers wrap by natural overflow.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
        end else if (flush_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= wdata_i;
                wr_ptr_q        <= wr_ptr_q + PTR_W'(1);
            end
            if (do_pop) rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: one outstanding 16-bit read per PC, results queued for decode.
// Define FETCH_PERF_EN to add saturating perf_fetched / perf_stall counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int ADDR_W  = FETCH_ADDR_W,
    parameter int INSTR_W = FETCH_INSTR_W,
    parameter int DEPTH   = 2
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [ADDR_W-1:0]  pc_addr,
    output logic               pc_incr,
    input  logic               redirect,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic               mem_read,
    input  logic               mem_waitrequest,
    input  logic [INSTR_W-1:0] mem_readdata,
    input  logic               mem_readdatavalid,
    output logic               instr_valid,
    input  logic               instr_ready,
    output logic [INSTR_W-1:0] instr,
    output logic [ADDR_W-1:0]  instr_pc
`ifdef FETCH_PERF_EN
    ,
    output logic [15:0]        perf_fetched,
    output logic [15:0]        perf_stall
`endif
);

    localparam int CNT_W = $clog2(DEPTH + 1);

    fetch_state_e        state_q, state_d;
    logic                mem_read_q, mem_read_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic                flush_pend_q, flush_pend_d;
    logic                q_push, incr_c, accept, slot_free;
    logic [CNT_W-1:0]    q_count;
    logic                q_full, q_empty;
    fetch_entry_t        q_head, q_wdata;

    assign accept    = mem_read_q & ~mem_waitrequest;
    assign slot_free = ~q_full && (CNT_W'(DEPTH) - q_count) >= CNT_W'(1);
    assign q_wdata   = '{pc: mem_addr_q, instr: mem_readdata};

    always_comb begin
        state_d      = state_q;
        mem_read_d   = mem_read_q;
        mem_addr_d   = mem_addr_q;
        flush_pend_d = flush_pend_q;
        q_push       = 1'b0;
        incr_c       = 1'b0;
        case (state_q)
            IDLE: begin
                if (slot_free && !redirect) begin
                    mem_addr_d = pc_addr;
                    mem_read_d = 1'b1;
                    state_d    = REQ;
                end
            end
            REQ: begin
                // A redirect cannot cancel an issued read; remember it so the
                // response is dropped and the PC is not stepped.
                if (accept) begin
                    mem_read_d   = 1'b0;
                    flush_pend_d = 1'b0;
                    if (redirect || flush_pend_q) begin
                        state_d = DRAIN;
                    end else begin
                        state_d = WAIT;
                        incr_c  = 1'b1;
                    end
                end else if (redirect) begin
                    flush_pend_d = 1'b1;
                end
            end
            WAIT: begin
                if (mem_readdatavalid) begin
                    state_d = IDLE;
                    q_push  = ~redirect;
                end else if (redirect) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (mem_readdatavalid) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            mem_read_q   <= 1'b0;
            mem_addr_q   <= '0;
            flush_pend_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            mem_read_q   <= mem_read_d;
            mem_addr_q   <= mem_addr_d;
            flush_pend_q <= flush_pend_d;
        end
    end

    instr_queue #(.DEPTH(DEPTH), .CNT_W(CNT_W)) u_queue (
        .clk     (clk),
        .reset   (reset),
        .push_i  (q_push),
        .pop_i   (instr_ready),
        .flush_i (redirect),
        .wdata_i (q_wdata),
        .rdata_o (q_head),
        .count_o (q_count),
        .full_o  (q_full),
        .empty_o (q_empty)
    );

    assign pc_incr     = incr_c & ~reset;
    assign mem_read    = mem_read_q;
    assign mem_addr    = mem_addr_q;
    assign instr_valid = ~q_empty;
    assign instr       = q_head.instr;
    assign instr_pc    = q_head.pc;

`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q <= '0;
            perf_stall_q   <= '0;
        end else begin
            if (q_push && perf_fetched_q != 16'hFFFF)
                perf_fetched_q <= perf_fetched_q + 16'd1;
            if (state_q == REQ && mem_waitrequest && perf_stall_q != 16'hFFFF)
                perf_stall_q <= perf_stall_q + 16'd1;
        end
    end

    assign perf_fetched = perf_fetched_q;
    assign perf_stall   = perf_stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit; inputs change 1ns after posedge, outputs sampled 3ns later.
// Build with FETCH_PERF_EN defined to also cover the performance counters.
module tb_fetch_unit;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] pc_addr;
    logic        pc_incr;
    logic        redirect;
    logic [15:0] mem_addr;
    logic        mem_read;
    logic        mem_waitrequest;
    logic [15:0] mem_readdata;
    logic        mem_readdatavalid;
    logic        instr_valid;
    logic        instr_ready;
    logic [15:0] instr;
    logic [15:0] instr_pc;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched, perf_stall;
`endif

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fetch_unit dut (
        .clk               (clk),
        .reset             (reset),
        .pc_addr           (pc_addr),
        .pc_incr           (pc_incr),
        .redirect          (redirect),
        .mem_addr          (mem_addr),
        .mem_read          (mem_read),
        .mem_waitrequest   (mem_waitrequest),
        .mem_readdata      (mem_readdata),
        .mem_readdatavalid (mem_readdatavalid),
        .instr_valid       (instr_valid),
        .instr_ready       (instr_ready),
        .instr             (instr),
        .instr_pc          (instr_pc)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched      (perf_fetched),
        .perf_stall        (perf_stall)
`endif
    );

    task automatic nxt;
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench 1ns after the last reset edge with reset released, DUT in IDLE.
    task automatic do_reset;
        reset = 1'b1; redirect = 1'b0; mem_readdatavalid = 1'b0; mem_waitrequest = 1'b0;
        instr_ready = 1'b1; pc_addr = 16'h0000; mem_readdata = 16'h0000;
        nxt; nxt;
        reset = 1'b0;
    endtask

    task automatic test_reset;
        reset = 1'b1; redirect = 1'b0; mem_readdatavalid = 1'b0; mem_waitrequest = 1'b0;
        instr_ready = 1'b1; pc_addr = 16'h1234; mem_readdata = 16'hBEEF;
        nxt; nxt; #3;
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL rst_mem_read got=%0h exp=0", mem_read); end
        checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL rst_mem_addr got=%0h exp=0", mem_addr); end
        checks++; if (pc_incr !== 1'b0) begin errors++; $display("FAIL rst_pc_incr got=%0h exp=0", pc_incr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL rst_instr_valid got=%0h exp=0", instr_valid); end
        checks++; if (instr !== 16'h0000) begin errors++; $display("FAIL rst_instr got=%0h exp=0", instr); end
        checks++; if (instr_pc !== 16'h0000) begin errors++; $display("FAIL rst_instr_pc got=%0h exp=0", instr_pc); end
`ifdef FETCH_PERF_EN
        checks++; if (perf_fetched !== 16'h0 || perf_stall !== 16'h0) begin errors++; $display("FAIL rst_perf got=%0h/%0h exp=0/0", perf_fetched, perf_stall); end
`endif
    endtask

    task automatic test_basic_fetch;
        do_reset;
        #3;
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL t1_idle_read got=%0h exp=0", mem_read); end
        nxt;
        #3;
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL t1_read0 got=%0h exp=1", mem_read); end
        checks++; if (mem_addr !== 16'h0000) begin errors++; $display("FAIL t1_addr0 got=%0h exp=0", mem_addr); end
        checks++; if (pc_incr !== 1'b1) begin errors++; $display("FAIL t1_incr0 got=%0h exp=1", pc_incr); end
        nxt;
        pc_addr = 16'h0002; mem_readdatavalid = 1'b1; mem_readdata = 16'h1111; #3;
        checks++; if (pc_incr !== 1'b0) begin errors++; $display("FAIL t1_incr_wait got=%0h exp=0", pc_incr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL t1_valid_early got=%0h exp=0", instr_valid); end
        nxt;
        mem_readdatavalid = 1'b0; #3;
        checks++; if (instr_valid !== 1'b1) begin errors++; $display("FAIL t1_valid0 got=%0h exp=1", instr_valid); end
        checks++; if (instr !== 16'h1111) begin errors++; $display("FAIL t1_instr0 got=%0h exp=1111", instr); end
        checks++; if (instr_pc !== 16'h0000) begin errors++; $display("FAIL t1_pc0 got=%0h exp=0", instr_pc); end
        nxt;
        #3;
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL t1_read1 got=%0h exp=1", mem_read); end
        checks++; if (mem_addr !== 16'h0002) begin errors++; $display("FAIL t1_addr1 got=%0h exp=2", mem_addr); end
        checks++; if (pc_incr !== 1'b1) begin errors++; $display("FAIL t1_incr1 got=%0h exp=1", pc_incr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL t1_popped got=%0h exp=0", instr_valid); end
        nxt;
        pc_addr = 16'h0004; mem_readdatavalid = 1'b1; mem_readdata = 16'h2222;
        nxt;
        mem_readdatavalid = 1'b0; #3;
        checks++; if (instr !== 16'h2222) begin errors++; $display("FAIL t1_instr1 got=%0h exp=2222", instr); end
        checks++; if (instr_pc !== 16'h0002) begin errors++; $display("FAIL t1_pc1 got=%0h exp=2", instr_pc); end
        nxt;
    endtask

    task automatic test_waitrequest;
        do_reset;
        nxt;
        mem_waitrequest = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #3;
            checks++; if (mem_read !== 1'b1 || mem_addr !== 16'h0000) begin errors++; $display("FAIL t2_hold%0d got=%0h/%0h exp=1/0", i, mem_read, mem_addr); end
            checks++; if (pc_incr !== 1'b0) begin errors++; $display("FAIL t2_noincr%0d got=%0h exp=0", i, pc_incr); end
            nxt;
        end
        mem_waitrequest = 1'b0; #3;
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL t2_read4 got=%0h exp=1", mem_read); end
        checks++; if (pc_incr !== 1'b1) begin errors++; $display("FAIL t2_incr got=%0h exp=1", pc_incr); end
        nxt;
        pc_addr = 16'h0002; mem_readdatavalid = 1'b1; mem_readdata = 16'h3333; #3;
        checks++; if (pc_incr !== 1'b0 || mem_read !== 1'b0) begin errors++; $display("FAIL t2_after got=%0h/%0h exp=0/0", pc_incr, mem_read); end
        nxt;
        mem_readdatavalid = 1'b0; #3;
        checks++; if (instr !== 16'h3333 || instr_pc !== 16'h0000) begin errors++; $display("FAIL t2_head got=%0h@%0h exp=3333@0", instr, instr_pc); end
`ifdef FETCH_PERF_EN
        checks++; if (perf_stall !== 16'd3) begin errors++; $display("FAIL t2_perf_stall got=%0d exp=3", perf_stall); end
        checks++; if (perf_fetched !== 16'd1) begin errors++; $display("FAIL t2_perf_fetched got=%0d exp=1", perf_fetched); end
`endif
        nxt;
    endtask

    task automatic test_backpressure;
        do_reset;
        instr_ready = 1'b0;
        nxt;
        #3;
        checks++; if (pc_incr !== 1'b1) begin errors++; $display("FAIL t3_incr0 got=%0h exp=1", pc_incr); end
        nxt;
        pc_addr = 16'h0002; mem_readdatavalid = 1'b1; mem_readdata = 16'hA000;
        nxt;
        mem_readdatavalid = 1'b0;
        nxt;
        #3;
        checks++; if (mem_addr !== 16'h0002 || pc_incr !== 1'b1) begin errors++; $display("FAIL t3_req1 got=%0h/%0h exp=2/1", mem_addr, pc_incr); end
        nxt;
        pc_addr = 16'h0004; mem_readdatavalid = 1'b1; mem_readdata = 16'hA002;
        nxt;
        mem_readdatavalid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #3;
            checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL t3_full_read%0d got=%0h exp=0", i, mem_read); end
            checks++; if (instr_valid !== 1'b1 || instr !== 16'hA000) begin errors++; $display("FAIL t3_full_head%0d got=%0h/%0h exp=1/a000", i, instr_valid, instr); end
            nxt;
        end
        instr_ready = 1'b1; #3;
        checks++; if (mem_read !== 1'b0 || instr_pc !== 16'h0000) begin errors++; $display("FAIL t3_resume got=%0h/%0h exp=0/0", mem_read, instr_pc); end
        nxt;
        #3;
        checks++; if (instr !== 16'hA002 || instr_pc !== 16'h0002) begin errors++; $display("FAIL t3_second got=%0h@%0h exp=a002@2", instr, instr_pc); end
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL t3_idle got=%0h exp=0", mem_read); end
        nxt;
        #3;
        checks++; if (mem_read !== 1'b1 || mem_addr !== 16'h0004) begin errors++; $display("FAIL t3_restart got=%0h/%0h exp=1/4", mem_read, mem_addr); end
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL t3_drained got=%0h exp=0", instr_valid); end
        nxt;
    endtask

    task automatic test_redirect_wait;
        do_reset;
        instr_ready = 1'b0;
        nxt; nxt;
        pc_addr = 16'h0002; mem_readdatavalid = 1'b1; mem_readdata = 16'h1234;
        nxt;
        mem_readdatavalid = 1'b0;
        nxt;
        #3;
        checks++; if (pc_incr !== 1'b1 || mem_addr !== 16'h0002) begin errors++; $display("FAIL t4_req got=%0h/%0h exp=1/2", pc_incr, mem_addr); end
        nxt;
        pc_addr = 16'h0004; redirect = 1'b1; #3;
        checks++; if (instr_valid !== 1'b1 || instr !== 16'h1234) begin errors++; $display("FAIL t4_prequeued got=%0h/%0h exp=1/1234", instr_valid, instr); end
        nxt;
        redirect = 1'b0; pc_addr = 16'h0100; mem_readdatavalid = 1'b1; mem_readdata = 16'hDEAD; #3;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL t4_flushed got=%0h exp=0", instr_valid); end
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL t4_drain_read got=%0h exp=0", mem_read); end
        nxt;
        mem_readdatavalid = 1'b0; #3;
        checks++; if (instr_valid !== 1'b0 || instr === 16'hDEAD) begin errors++; $display("FAIL t4_discard got=%0h/%0h exp=0/not-dead", instr_valid, instr); end
        nxt;
        #3;
        checks++; if (mem_read !== 1'b1 || mem_addr !== 16'h0100) begin errors++; $display("FAIL t4_newpc got=%0h/%0h exp=1/100", mem_read, mem_addr); end
        checks++; if (pc_incr !== 1'b1) begin errors++; $display("FAIL t4_incr got=%0h exp=1", pc_incr); end
        nxt;
        pc_addr = 16'h0102; mem_readdatavalid = 1'b1; mem_readdata = 16'h4444;
        nxt;
        mem_readdatavalid = 1'b0; #3;
        checks++; if (instr_valid !== 1'b1 || instr !== 16'h4444 || instr_pc !== 16'h0100) begin errors++; $display("FAIL t4_head got=%0h:%0h@%0h exp=1:4444@100", instr_valid, instr, instr_pc); end
        nxt;
    endtask

    task automatic test_redirect_req;
        do_reset;
        nxt;
        mem_waitrequest = 1'b1; redirect = 1'b1; #3;
        checks++; if (pc_incr !== 1'b0 || mem_read !== 1'b1) begin errors++; $display("FAIL t5_stall got=%0h/%0h exp=0/1", pc_incr, mem_read); end
        nxt;
        redirect = 1'b0; pc_addr = 16'h0200; #3;
        checks++; if (mem_read !== 1'b1 || mem_addr !== 16'h0000) begin errors++; $display("FAIL t5_held got=%0h/%0h exp=1/0", mem_read, mem_addr); end
        nxt;
        mem_waitrequest = 1'b0; #3;
        checks++; if (mem_read !== 1'b1) begin errors++; $display("FAIL t5_accept_read got=%0h exp=1", mem_read); end
        checks++; if (pc_incr !== 1'b0) begin errors++; $display("FAIL t5_accept_incr got=%0h exp=0", pc_incr); end
        nxt;
        mem_readdatavalid = 1'b1; mem_readdata = 16'hDEAD; #3;
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL t5_drain got=%0h exp=0", mem_read); end
        nxt;
        mem_readdatavalid = 1'b0; #3;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL t5_discard got=%0h exp=0", instr_valid); end
        nxt;
        #3;
        checks++; if (mem_read !== 1'b1 || mem_addr !== 16'h0200) begin errors++; $display("FAIL t5_newpc got=%0h/%0h exp=1/200", mem_read, mem_addr); end
        nxt;
    endtask

    task automatic test_redirect_same_cycle;
        do_reset;
        redirect = 1'b1;
        nxt;
        redirect = 1'b0; pc_addr = 16'h0300; #3;
        checks++; if (mem_read !== 1'b0) begin errors++; $display("FAIL t7_idle_redirect got=%0h exp=0", mem_read); end
        nxt;
        #3;
        checks++; if (mem_read !== 1'b1 || mem_addr !== 16'h0300 || pc_incr !== 1'b1) begin errors++; $display("FAIL t7_req got=%0h/%0h/%0h exp=1/300/1", mem_read, mem_addr, pc_incr); end
        nxt;
        pc_addr = 16'h0302; mem_readdatavalid = 1'b1; mem_readdata = 16'hDEAD; redirect = 1'b1;
        nxt;
        mem_readdatavalid = 1'b0; redirect = 1'b0; pc_addr = 16'h0400; #3;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL t7_discard got=%0h exp=0", instr_valid); end
        nxt;
        #3;
        checks++; if (mem_read !== 1'b1 || mem_addr !== 16'h0400) begin errors++; $display("FAIL t7_newpc got=%0h/%0h exp=1/400", mem_read, mem_addr); end
        nxt;
    endtask

    task automatic test_reset_in_wait;
        do_reset;
        nxt; nxt;
        pc_addr = 16'h0002; reset = 1'b1;
        nxt;
        reset = 1'b0; pc_addr = 16'h0000; mem_readdatavalid = 1'b1; mem_readdata = 16'hDEAD; #3;
        checks++; if (mem_read !== 1'b0 || instr_valid !== 1'b0) begin errors++; $display("FAIL t6_after_rst got=%0h/%0h exp=0/0", mem_read, instr_valid); end
        nxt;
        mem_readdatavalid = 1'b0; #3;
        checks++; if (instr_valid !== 1'b0) begin errors++; $display("FAIL t6_late_rdv got=%0h exp=0", instr_valid); end
        checks++; if (mem_read !== 1'b1 || mem_addr !== 16'h0000) begin errors++; $display("FAIL t6_refetch got=%0h/%0h exp=1/0", mem_read, mem_addr); end
`ifdef FETCH_PERF_EN
        checks++; if (perf_fetched !== 16'd0) begin errors++; $display("FAIL t6_perf got=%0d exp=0", perf_fetched); end
`endif
        nxt;
    endtask

    initial begin
        test_reset;
        test_basic_fetch;
        test_waitrequest;
        test_backpressure;
        test_redirect_wait;
        test_redirect_req;
        test_redirect_same_cycle;
        test_reset_in_wait;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
